eeprom_read_arbiter: RTL

Sequences read cycles on the 64K×8 parallel EEPROM and shares it between two requesters. The block sits between the base-conversion datapath (two lookup clients) and the EEPROM. It owns the EEPROM `cs_n`, `oe_n` and `addr` pins and times each access with a programmable wait count. Each read returns the captured byte to the winning requester with a one-cycle valid pulse.

---
 rtl/eeprom_read_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/eeprom_read_arbiter.sv
// Two-port read arbiter and cycle sequencer for a 64Kx8 parallel EEPROM.
// Define EEPROM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module eeprom_read_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int TURNAROUND    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              busy,
  output logic              ee_cs_n,
  output logic              ee_oe_n,
  output logic [ADDR_W-1:0] ee_addr,
  input  logic [DATA_W-1:0] ee_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] TA_LOAD  = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  logic [2:0] state;
  logic [3:0] wait_cnt;
  logic       winner;
  logic       pick;

`ifdef EEPROM_ARB_RR_EN
  logic rr_ptr;

  // On a tie the pointer decides; a lone request always wins. Either way the
  // pointer then favours the port that did not win.
  assign pick = (req0 && req1) ? rr_ptr : !req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (state == S_IDLE && (req0 || req1)) begin
      rr_ptr <= !pick;
    end
  end
`else
  assign pick = !req0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      winner   <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      busy     <= 1'b0;
      ee_cs_n  <= 1'b1;
      ee_oe_n  <= 1'b1;
      ee_addr  <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            winner  <= pick;
            ee_addr <= pick ? addr1 : addr0;
            busy    <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          gnt0     <= !winner;
          gnt1     <= winner;
          ee_cs_n  <= 1'b0;
          ee_oe_n  <= 1'b1;
          wait_cnt <= ACC_LOAD;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          ee_oe_n <= 1'b0;
          if (wait_cnt == 4'd0) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          // Data is taken on the edge that ends the output-enable window, so it
          // has had the full ACCESS_CYCLES periods to settle.
          if (winner) begin
            rdata1  <= ee_data;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ee_data;
            rvalid0 <= 1'b1;
          end
          ee_cs_n <= 1'b1;
          ee_oe_n <= 1'b1;
          if (TURNAROUND > 0) begin
            wait_cnt <= TA_LOAD;
            state    <= S_RECOVER;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RECOVER: begin
          if (wait_cnt == 4'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          busy    <= 1'b0;
          ee_cs_n <= 1'b1;
          ee_oe_n <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
